// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer: op codes, widths, FSM states and
// per-op beat helpers.
package stack_sequencer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] SP_RESET_DEF = 32'h000F_FFFF;
  localparam logic [ADDR_W-1:0] SP_LIMIT_DEF = 32'h000F_F000;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_INT  = 3'd5;
  localparam logic [2:0] OP_RTI  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Number of memory beats an op needs; zero for NOP and the reserved code.
  function automatic logic [1:0] beat_count(input logic [2:0] op);
    case (op)
      OP_PUSH, OP_POP: beat_count = 2'd1;
      OP_CALL, OP_RET: beat_count = 2'd2;
      OP_INT,  OP_RTI: beat_count = 2'd3;
      default:         beat_count = 2'd0;
    endcase
  endfunction

  function automatic logic is_push(input logic [2:0] op);
    is_push = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Data-memory beat port between the stack sequencer (master) and the memory
// arbiter (slave). One 16-bit word per beat, request held until ack.
interface stack_sequencer_if;

  logic                                  mem_req;
  logic                                  mem_we;
  logic [stack_sequencer_pkg::ADDR_W-1:0] mem_addr;
  logic [stack_sequencer_pkg::DATA_W-1:0] mem_wdata;
  logic                                  mem_ack;
  logic [stack_sequencer_pkg::DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/stack_sequencer_sp_addr_unit.sv
// Combinational beat address and post-beat SP: writes go to mem[sp] then
// decrement, reads come from mem[sp+1] then increment.
module sp_addr_unit
  import stack_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] sp,
  input  logic              is_write,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] sp_next
);

  always_comb begin
    if (is_write) begin
      addr    = sp;
      sp_next = sp - ADDR_W'(1);
    end else begin
      addr    = sp + ADDR_W'(1);
      sp_next = sp + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Stack sequencer: owns SP, turns PUSH/POP/CALL/RET/INT/RTI into 16-bit memory
// beats and stalls decode while busy. Widths are fixed at 32-bit PC / 16-bit words.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SP_RESET = SP_RESET_DEF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  input  logic [2:0]          op_code,
  output logic                op_ready,
  input  logic [DATA_W-1:0]   push_data,
  input  logic [ADDR_W-1:0]   pc_in,
  input  logic [3:0]          flags_in,
  stack_sequencer_if.master   mem,
  output logic                pop_valid,
  output logic [DATA_W-1:0]   pop_data,
  output logic                pc_valid,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                flags_valid,
  output logic [3:0]          flags_out,
  output logic [ADDR_W-1:0]   sp,
  output logic                stall,
  output logic                stack_fault
);

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [1:0]          beat_q;
  logic [ADDR_W-1:0]   sp_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [3:0]          flags_q;
  logic [DATA_W-1:0]   data_q;
  logic                fault_q;
  logic [DATA_W-1:0]   pop_data_q;
  logic [ADDR_W-1:0]   pc_out_q;
  logic [3:0]          flags_out_q;

  logic                accept, legal, go;
  logic [1:0]          n_in;
  logic                beat_write, beat_done, last_beat;
  logic [ADDR_W-1:0]   beat_addr, sp_next;
  logic [DATA_W-1:0]   wdata;
  logic [ADDR_W-1:0]   pc_cap;
  logic [3:0]          flags_cap;
  logic [DATA_W-1:0]   data_cap;

  // Bounds are checked once at accept so SP can never leave [SP_LIMIT-1, SP_RESET].
  assign accept = op_valid && (state_q == ST_IDLE);
  assign n_in   = beat_count(op_code);
  assign legal  = is_push(op_code)
                ? ((sp_q - SP_LIMIT + ADDR_W'(1)) >= ADDR_W'(n_in))
                : ((SP_RESET - sp_q) >= ADDR_W'(n_in));
  assign go     = accept && legal && (n_in != 2'd0);

  assign beat_write = is_push(op_q);
  assign beat_done  = (state_q == ST_ACCESS) && mem.mem_ack;
  assign last_beat  = (beat_q == (beat_count(op_q) - 2'd1));

  sp_addr_unit u_sp_addr (
    .sp       (sp_q),
    .is_write (beat_write),
    .addr     (beat_addr),
    .sp_next  (sp_next)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wdata     = '0;
    pc_cap    = pc_q;
    flags_cap = flags_q;
    data_cap  = data_q;
    case (op_q)
      OP_PUSH: wdata = data_q;
      OP_CALL: wdata = (beat_q == 2'd0) ? pc_q[31:16] : pc_q[15:0];
      OP_INT: begin
        case (beat_q)
          2'd0:    wdata = {12'h000, flags_q};
          2'd1:    wdata = pc_q[31:16];
          default: wdata = pc_q[15:0];
        endcase
      end
      default: wdata = '0;
    endcase
    if (beat_done && !beat_write) begin
      if (op_q == OP_POP) begin
        data_cap = mem.mem_rdata;
      end else begin
        case (beat_q)
          2'd0:    pc_cap[15:0]  = mem.mem_rdata;
          2'd1:    pc_cap[31:16] = mem.mem_rdata;
          default: flags_cap     = mem.mem_rdata[3:0];
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go) state_d = ST_ACCESS;
      ST_ACCESS: if (beat_done && last_beat) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_NOP;
      beat_q      <= 2'd0;
      sp_q        <= SP_RESET;
      pc_q        <= '0;
      flags_q     <= '0;
      data_q      <= '0;
      fault_q     <= 1'b0;
      pop_data_q  <= '0;
      pc_out_q    <= '0;
      flags_out_q <= '0;
    end else begin
      fault_q <= accept && !legal;
      if (go) begin
        op_q    <= op_code;
        beat_q  <= 2'd0;
        pc_q    <= pc_in;
        flags_q <= flags_in;
        data_q  <= push_data;
      end else if (beat_done) begin
        sp_q    <= sp_next;
        beat_q  <= beat_q + 2'd1;
        pc_q    <= pc_cap;
        flags_q <= flags_cap;
        data_q  <= data_cap;
        // Results become visible together in DONE; held until the next producer.
        if (last_beat) begin
          case (op_q)
            OP_POP: pop_data_q <= data_cap;
            OP_RET: pc_out_q   <= pc_cap;
            OP_RTI: begin
              pc_out_q    <= pc_cap;
              flags_out_q <= flags_cap;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign op_ready      = (state_q == ST_IDLE);
  assign stall         = !op_ready;
  assign mem.mem_req   = (state_q == ST_ACCESS);
  assign mem.mem_we    = mem.mem_req && beat_write;
  assign mem.mem_addr  = mem.mem_req ? beat_addr : '0;
  assign mem.mem_wdata = (mem.mem_req && beat_write) ? wdata : '0;

  assign pop_valid   = (state_q == ST_DONE) && (op_q == OP_POP);
  assign pc_valid    = (state_q == ST_DONE) && ((op_q == OP_RET) || (op_q == OP_RTI));
  assign flags_valid = (state_q == ST_DONE) && (op_q == OP_RTI);
  assign pop_data    = pop_data_q;
  assign pc_out      = pc_out_q;
  assign flags_out   = flags_out_q;
  assign sp          = sp_q;
  assign stack_fault = fault_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed vector table, reset/limit
// sequences and random ops against a queue-based transaction model.
`timescale 1ns/1ps
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  localparam logic [31:0] SPR = 32'h000F_FFFF;
  localparam logic [31:0] SPL = 32'h000F_F000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        op_ready;
  logic [15:0] push_data;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic        pc_valid;
  logic [31:0] pc_out;
  logic        flags_valid;
  logic [3:0]  flags_out;
  logic [31:0] sp;
  logic        stall;
  logic        stack_fault;

  always #5 clk = ~clk;

  stack_sequencer_if mem ();

  stack_sequencer #(.SP_RESET(SPR), .SP_LIMIT(SPL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_ready    (op_ready),
    .push_data   (push_data),
    .pc_in       (pc_in),
    .flags_in    (flags_in),
    .mem         (mem),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .pc_valid    (pc_valid),
    .pc_out      (pc_out),
    .flags_valid (flags_valid),
    .flags_out   (flags_out),
    .sp          (sp),
    .stall       (stall),
    .stack_fault (stack_fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [15:0] data;
  } beat_t;

  // Memory responder: acks after ack_delay waiting cycles, logs every beat.
  beat_t       log_q[$];
  logic [15:0] env_mem [int unsigned];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  beat_t       held;

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mem.mem_req === 1'b1 && rst_n === 1'b1) begin
        if (wait_cnt > 0)
          check("req_stable", {mem.mem_we, mem.mem_addr, mem.mem_wdata}, held);
        else
          held = {mem.mem_we, mem.mem_addr, mem.mem_wdata};
        if (wait_cnt >= ack_delay) begin
          mem.mem_ack = 1'b1;
          wait_cnt = 0;
          if (mem.mem_we) begin
            env_mem[mem.mem_addr] = mem.mem_wdata;
            log_q.push_back({1'b1, mem.mem_addr, mem.mem_wdata});
            mem.mem_rdata = 16'($urandom);
          end else begin
            mem.mem_rdata = env_mem.exists(mem.mem_addr) ? env_mem[mem.mem_addr] : 16'hDEAD;
            log_q.push_back({1'b0, mem.mem_addr, mem.mem_rdata});
          end
        end else begin
          mem.mem_ack = 1'b0;
          mem.mem_rdata = 16'($urandom);
          wait_cnt++;
        end
      end else begin
        mem.mem_ack = 1'b0;
        mem.mem_rdata = 16'($urandom);
        wait_cnt = 0;
      end
    end
  end

  // Transaction-level reference: a word-addressed stack with explicit bounds.
  logic [31:0] m_sp;
  logic [15:0] m_mem [int unsigned];
  logic [15:0] m_pop;
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  beat_t       exp_q[$];

  task automatic model_reset();
    m_sp = SPR; m_pop = '0; m_pc = '0; m_flags = '0;
    m_mem.delete();
  endtask

  task automatic model_op(input logic [2:0] op, input logic [15:0] d, input logic [31:0] pc,
                          input logic [3:0] fl, output logic fault, output int n);
    logic [15:0] words[$];
    logic [15:0] got[$];
    logic [15:0] w;
    bit          push;
    exp_q.delete();
    push = 1'b0; n = 0; fault = 1'b0;
    case (op)
      OP_PUSH: begin push = 1'b1; words.push_back(d); end
      OP_CALL: begin push = 1'b1; words.push_back(pc[31:16]); words.push_back(pc[15:0]); end
      OP_INT:  begin
        push = 1'b1;
        words.push_back({12'h000, fl}); words.push_back(pc[31:16]); words.push_back(pc[15:0]);
      end
      OP_POP:  n = 1;
      OP_RET:  n = 2;
      OP_RTI:  n = 3;
      default: n = 0;
    endcase
    if (push) n = words.size();
    if (push) fault = (longint'(m_sp) - longint'(SPL) + 1) < longint'(n);
    else      fault = (longint'(SPR) - longint'(m_sp)) < longint'(n);
    if (fault || n == 0) return;
    if (push) begin
      foreach (words[i]) begin
        exp_q.push_back({1'b1, m_sp, words[i]});
        m_mem[m_sp] = words[i];
        m_sp = m_sp - 1;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        m_sp = m_sp + 1;
        w = m_mem.exists(m_sp) ? m_mem[m_sp] : 16'hDEAD;
        got.push_back(w);
        exp_q.push_back({1'b0, m_sp, w});
      end
      case (op)
        OP_POP: m_pop = got[0];
        OP_RET: m_pc  = {got[1], got[0]};
        default: begin m_pc = {got[1], got[0]}; m_flags = got[2][3:0]; end
      endcase
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] d, input logic [31:0] pc,
                        input logic [3:0] fl, input int delay, input bit junk,
                        output logic obs_fault);
    logic mfault;
    int n, cyc, e_lat, e_req;
    int fault_cnt, req_cnt, pop_cnt, pc_cnt, fl_cnt, pop_cyc, pc_cyc, fl_cyc;
    bit e_pop, e_pc, e_fl;
    logic [15:0] pop_seen;
    model_op(op, d, pc, fl, mfault, n);
    ack_delay = delay;
    log_q.delete();
    @(posedge clk); #1;
    cyc = 0;
    while (!op_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("ready_before_op", op_ready, 1'b1);
    op_valid = 1'b1; op_code = op; push_data = d; pc_in = pc; flags_in = fl;
    @(posedge clk); #1;
    if (junk && !mfault && n > 0) begin
      op_code = OP_PUSH; push_data = 16'($urandom); pc_in = $urandom;
    end else begin
      op_valid = 1'b0;
    end
    fault_cnt = 0; req_cnt = 0; pop_cnt = 0; pc_cnt = 0; fl_cnt = 0;
    pop_cyc = -1; pc_cyc = -1; fl_cyc = -1; pop_seen = '0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (stack_fault) fault_cnt++;
      if (mem.mem_req) req_cnt++;
      if (pop_valid) begin pop_cnt++; pop_cyc = cyc; pop_seen = pop_data; end
      if (pc_valid) begin pc_cnt++; pc_cyc = cyc; end
      if (flags_valid) begin fl_cnt++; fl_cyc = cyc; end
    end while (!op_ready && cyc < 400);
    op_valid = 1'b0;

    e_lat = (mfault || n == 0) ? 1 : n * (delay + 1) + 2;
    e_req = (mfault || n == 0) ? 0 : n * (delay + 1);
    e_pop = !mfault && op == OP_POP;
    e_pc  = !mfault && (op == OP_RET || op == OP_RTI);
    e_fl  = !mfault && op == OP_RTI;
    check("latency", cyc, e_lat);
    check("fault_pulse", fault_cnt, mfault);
    check("req_cycles", req_cnt, e_req);
    check("beat_count", log_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < log_q.size()) check("beat", log_q[i], exp_q[i]);
    check("pop_valid_pulses", pop_cnt, e_pop);
    check("pc_valid_pulses", pc_cnt, e_pc);
    check("flags_valid_pulses", fl_cnt, e_fl);
    if (e_pop) begin
      check("pop_valid_cycle", pop_cyc, cyc - 1);
      check("pop_data_at_valid", pop_seen, m_pop);
    end
    if (e_pc) check("pc_valid_cycle", pc_cyc, cyc - 1);
    if (e_fl) check("flags_valid_cycle", fl_cyc, cyc - 1);
    check("sp", sp, m_sp);
    check("pop_data_held", pop_data, m_pop);
    check("pc_out_held", pc_out, m_pc);
    check("flags_out_held", flags_out, m_flags);
    check("stall_idle", stall, 1'b0);
    obs_fault = (fault_cnt != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem.mem_req, 1'b0);
    check("rst_sp", sp, SPR);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("rel_sp", sp, SPR);
    check("rel_op_ready", op_ready, 1'b1);
    check("rel_mem", {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata}, '0);
    check("rel_valids", {pop_valid, pc_valid, flags_valid, stack_fault}, 4'b0000);
    check("rel_results", {pop_data, pc_out, flags_out}, '0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [31:0] pc;
    logic [3:0]  flags;
    int          delay;
    logic        fault;
    logic [31:0] sp;
    logic [15:0] pop;
    logic [31:0] pco;
    logic [3:0]  flo;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic f;
    int   cyc;
    op_valid = 1'b0; op_code = '0; push_data = '0; pc_in = '0; flags_in = '0;

    vecs[0]  = '{OP_PUSH, 16'hBEEF, 32'h0,          4'h0, 0, 1'b0, 32'h000F_FFFE, 16'h0000, 32'h0,          4'h0};
    vecs[1]  = '{OP_POP,  16'h0,    32'h0,          4'h0, 0, 1'b0, 32'h000F_FFFF, 16'hBEEF, 32'h0,          4'h0};
    vecs[2]  = '{OP_CALL, 16'h0,    32'h1234_5678,  4'h0, 0, 1'b0, 32'h000F_FFFD, 16'hBEEF, 32'h0,          4'h0};
    vecs[3]  = '{OP_RET,  16'h0,    32'h0,          4'h0, 0, 1'b0, 32'h000F_FFFF, 16'hBEEF, 32'h1234_5678,  4'h0};
    vecs[4]  = '{OP_INT,  16'h0,    32'h0000_0100,  4'hA, 3, 1'b0, 32'h000F_FFFC, 16'hBEEF, 32'h1234_5678,  4'h0};
    vecs[5]  = '{OP_RTI,  16'h0,    32'h0,          4'h0, 3, 1'b0, 32'h000F_FFFF, 16'hBEEF, 32'h0000_0100,  4'hA};
    vecs[6]  = '{OP_POP,  16'h0,    32'h0,          4'h0, 0, 1'b1, 32'h000F_FFFF, 16'hBEEF, 32'h0000_0100,  4'hA};
    vecs[7]  = '{OP_RTI,  16'h0,    32'h0,          4'h0, 0, 1'b1, 32'h000F_FFFF, 16'hBEEF, 32'h0000_0100,  4'hA};
    vecs[8]  = '{OP_NOP,  16'h5555, 32'h0,          4'h0, 0, 1'b0, 32'h000F_FFFF, 16'hBEEF, 32'h0000_0100,  4'hA};
    vecs[9]  = '{OP_RSVD, 16'h5555, 32'h0,          4'h0, 0, 1'b0, 32'h000F_FFFF, 16'hBEEF, 32'h0000_0100,  4'hA};
    vecs[10] = '{OP_PUSH, 16'h1234, 32'h0,          4'h0, 1, 1'b0, 32'h000F_FFFE, 16'hBEEF, 32'h0000_0100,  4'hA};
    vecs[11] = '{OP_POP,  16'h0,    32'h0,          4'h0, 2, 1'b0, 32'h000F_FFFF, 16'h1234, 32'h0000_0100,  4'hA};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].data, vecs[i].pc, vecs[i].flags, vecs[i].delay, 1'b0, f);
      check($sformatf("tbl%0d_fault", i), f, vecs[i].fault);
      check($sformatf("tbl%0d_sp", i), sp, vecs[i].sp);
      check($sformatf("tbl%0d_pop", i), pop_data, vecs[i].pop);
      check($sformatf("tbl%0d_pc", i), pc_out, vecs[i].pco);
      check($sformatf("tbl%0d_flags", i), flags_out, vecs[i].flo);
      if (i == 2) begin
        check("call_word_hi", env_mem[32'h000F_FFFF], 16'h1234);
        check("call_word_lo", env_mem[32'h000F_FFFE], 16'h5678);
      end
      if (i == 3 && log_q.size() == 2) begin
        check("ret_read0_addr", log_q[0].addr, 32'h000F_FFFE);
        check("ret_read1_addr", log_q[1].addr, 32'h000F_FFFF);
      end
    end

    // Requests arriving while busy must be ignored, not queued.
    run_op(OP_CALL, 16'h0, 32'hCAFE_F00D, 4'h0, 1, 1'b1, f);
    run_op(OP_RET, 16'h0, 32'h0, 4'h0, 0, 1'b1, f);
    check("busy_ignored_pc", pc_out, 32'hCAFE_F00D);
    check("busy_ignored_sp", sp, SPR);

    // Reset in the middle of an INT after its first beat.
    ack_delay = 3;
    log_q.delete();
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_INT; pc_in = 32'h0000_0100; flags_in = 4'b1010;
    @(posedge clk); #1;
    op_valid = 1'b0;
    cyc = 0;
    while (log_q.size() < 1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check("midint_first_ack", log_q.size(), 1);
    @(posedge clk); #1;
    check("midint_sp_after_ack", sp, 32'h000F_FFFE);
    check("midint_req_busy", mem.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midint_req_drop", mem.mem_req, 1'b0);
    check("midint_sp_reset", sp, SPR);
    check("midint_ready", op_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      run_op(3'($urandom_range(0, 7)), 16'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), f);
    end

    // Fill the stack down to SP_LIMIT and probe the overflow boundary.
    do_reset();
    for (int k = 0; k < 4095; k++) run_op(OP_PUSH, 16'(k), 32'h0, 4'h0, 0, 1'b0, f);
    check("fill_sp_at_limit", sp, SPL);
    run_op(OP_CALL, 16'h0, 32'hAAAA_5555, 4'h0, 0, 1'b0, f);
    check("limit_call_fault", f, 1'b1);
    check("limit_call_sp", sp, SPL);
    run_op(OP_PUSH, 16'h7777, 32'h0, 4'h0, 0, 1'b0, f);
    check("limit_push_ok", f, 1'b0);
    check("limit_push_sp", sp, SPL - 32'd1);
    run_op(OP_PUSH, 16'h8888, 32'h0, 4'h0, 0, 1'b0, f);
    check("below_limit_push_fault", f, 1'b1);
    run_op(OP_POP, 16'h0, 32'h0, 4'h0, 0, 1'b0, f);
    check("limit_pop_data", pop_data, 16'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
